// File: rtl/vscale_xvec_alu_seq_if.sv
// Request/response bundle between the xvec issue stage and the sequenced xvec ALU.
// XVEC_SEQ_LANE_MASK_EN adds the per-lane req_mask field.
interface vscale_xvec_alu_seq_if #(
    parameter int unsigned XPR_LEN      = 32,
    parameter int unsigned NLANES       = 32,
    parameter int unsigned ALU_OP_WIDTH = 4
);
    logic                        req_valid;
    logic                        req_ready;
    logic [ALU_OP_WIDTH-1:0]     req_op;
    logic                        req_xvec;
    logic [NLANES*XPR_LEN-1:0]   req_in1;
    logic [NLANES*XPR_LEN-1:0]   req_in2;
`ifdef XVEC_SEQ_LANE_MASK_EN
    logic [NLANES-1:0]           req_mask;
`endif
    logic                        resp_valid;
    logic                        resp_ready;
    logic [NLANES*XPR_LEN-1:0]   resp_out;

    modport master (
        output req_valid, req_op, req_xvec, req_in1, req_in2,
`ifdef XVEC_SEQ_LANE_MASK_EN
        output req_mask,
`endif
        output resp_ready,
        input  req_ready, resp_valid, resp_out
    );

    modport slave (
        input  req_valid, req_op, req_xvec, req_in1, req_in2,
`ifdef XVEC_SEQ_LANE_MASK_EN
        input  req_mask,
`endif
        input  resp_ready,
        output req_ready, resp_valid, resp_out
    );
endinterface

// File: rtl/vscale_xvec_alu_seq.sv
// Runs one xvec ALU op across NLANES lanes by streaming GROUP lanes per cycle through a
// shared ALU slice. XVEC_SEQ_LANE_MASK_EN enables per-lane masking with in1 merge.
module vscale_xvec_alu_seq #(
    parameter int unsigned XPR_LEN      = 32,
    parameter int unsigned NLANES       = 32,
    parameter int unsigned GROUP        = 4,
    parameter int unsigned ALU_OP_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    vscale_xvec_alu_seq_if.slave       bus,
    output logic                       busy,
    output logic [ALU_OP_WIDTH-1:0]    alu_op,
    output logic [GROUP*XPR_LEN-1:0]   alu_in1,
    output logic [GROUP*XPR_LEN-1:0]   alu_in2,
    input  logic [GROUP*XPR_LEN-1:0]   alu_out
);
    localparam int unsigned NGRP = NLANES / GROUP;
    localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned SW   = GROUP * XPR_LEN;
    localparam int unsigned VW   = NLANES * XPR_LEN;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA = ALU_OP_WIDTH'(11);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [GW-1:0]           grp_q, grp_d;
    logic [ALU_OP_WIDTH-1:0] op_q;
    logic [VW-1:0]           in1_q, in2_q;
    logic [NLANES-1:0]       en_q;
    logic [VW-1:0]           buf_q, buf_d;

    logic              accept;
    logic              acc_vec;
    logic [NLANES-1:0] acc_en;
    logic [NLANES-1:0] acc_merge;
    logic              acc_found;
    logic [GW-1:0]     acc_grp;
    logic              nxt_found;
    logic [GW-1:0]     nxt_grp;
    logic [SW-1:0]     sel_in1, sel_in2;

    function automatic logic is_vec_op(input logic [ALU_OP_WIDTH-1:0] op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SRL,
            ALU_OP_SRA, ALU_OP_XOR, ALU_OP_OR, ALU_OP_AND: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    assign accept         = (state_q == StIdle) && bus.req_valid;
    assign bus.req_ready  = (state_q == StIdle) && !reset;
    assign bus.resp_valid = (state_q == StDone);
    assign bus.resp_out   = buf_q;
    assign busy           = (state_q != StIdle);
    assign alu_op         = op_q;

    // Lane enables at acceptance; the group count falls out of which groups have any enable.
    always_comb begin
        acc_vec = bus.req_xvec && is_vec_op(bus.req_op);
        acc_en  = '0;
        if (acc_vec) begin
            acc_en = '1;
        end else begin
            acc_en[0] = 1'b1;
        end
        acc_merge = '0;
`ifdef XVEC_SEQ_LANE_MASK_EN
        acc_en = acc_en & bus.req_mask;
        for (int i = 0; i < int'(NLANES); i++) begin
            acc_merge[i] = !acc_en[i] && (acc_vec || (i == 0));
        end
`endif
        acc_found = 1'b0;
        acc_grp   = '0;
        for (int g = int'(NGRP) - 1; g >= 0; g--) begin
            if (|acc_en[g*GROUP +: GROUP]) begin
                acc_found = 1'b1;
                acc_grp   = GW'(g);
            end
        end
        // Descending scan so the lowest enabled group above grp_q wins.
        nxt_found = 1'b0;
        nxt_grp   = '0;
        for (int g = int'(NGRP) - 1; g >= 0; g--) begin
            if ((g > int'(grp_q)) && (|en_q[g*GROUP +: GROUP])) begin
                nxt_found = 1'b1;
                nxt_grp   = GW'(g);
            end
        end
    end

    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int g = 0; g < int'(NGRP); g++) begin
            if (grp_q == GW'(g)) begin
                sel_in1 = in1_q[g*SW +: SW];
                sel_in2 = in2_q[g*SW +: SW];
            end
        end
        alu_in1 = sel_in1;
        // SLL/SRA take a uniform shift amount from lane 0; SRL stays per-lane.
        if (op_q == ALU_OP_SLL || op_q == ALU_OP_SRA) begin
            alu_in2 = {GROUP{in2_q[XPR_LEN-1:0]}};
        end else begin
            alu_in2 = sel_in2;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        buf_d   = buf_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    for (int i = 0; i < int'(NLANES); i++) begin
                        buf_d[i*XPR_LEN +: XPR_LEN] =
                            acc_merge[i] ? bus.req_in1[i*XPR_LEN +: XPR_LEN] : '0;
                    end
                    grp_d   = acc_grp;
                    state_d = acc_found ? StRun : StDone;
                end
            end
            StRun: begin
                for (int g = 0; g < int'(NGRP); g++) begin
                    for (int l = 0; l < int'(GROUP); l++) begin
                        if ((grp_q == GW'(g)) && en_q[g*GROUP + l]) begin
                            buf_d[(g*GROUP + l)*XPR_LEN +: XPR_LEN] =
                                alu_out[l*XPR_LEN +: XPR_LEN];
                        end
                    end
                end
                if (nxt_found) begin
                    grp_d = nxt_grp;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grp_q   <= '0;
            buf_q   <= '0;
            op_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            buf_q   <= buf_d;
            if (accept) begin
                op_q  <= bus.req_op;
                in1_q <= bus.req_in1;
                in2_q <= bus.req_in2;
                en_q  <= acc_en;
            end
        end
    end
endmodule
